// File: rtl/mux_scan_ctrl.sv
// Select sequencer for the 4:1 dataflow mux: scans channels 0..3,
// samples y at the end of each dwell and publishes a 4-bit snapshot.
module mux_scan_ctrl #(
  parameter int DWELL_W = 8,
  parameter int CNT_W   = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               abort,
  input  logic               cont,
  input  logic [DWELL_W-1:0] dwell,
  input  logic               y,
  output logic               s1,
  output logic               s0,
  output logic               busy,
  output logic [3:0]         snap,
  output logic               snap_valid,
  output logic [CNT_W-1:0]   scan_cnt
);

  typedef enum logic {
    IDLE = 1'b0,
    SCAN = 1'b1
  } state_t;

  state_t             state;
  logic [1:0]         ch;
  logic [DWELL_W-1:0] dcnt;
  logic [DWELL_W-1:0] d_lat;
  logic [2:0]         shadow;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      ch         <= 2'd0;
      dcnt       <= '0;
      d_lat      <= '0;
      shadow     <= 3'd0;
      s1         <= 1'b0;
      s0         <= 1'b0;
      busy       <= 1'b0;
      snap       <= 4'd0;
      snap_valid <= 1'b0;
      scan_cnt   <= '0;
    end else begin
      snap_valid <= 1'b0;
      unique case (state)
        IDLE: begin
          {s1, s0} <= 2'b00;
          busy     <= 1'b0;
          if (start && !abort) begin
            state <= SCAN;
            ch    <= 2'd0;
            dcnt  <= DWELL_W'(1);
            d_lat <= (dwell == '0) ? DWELL_W'(1) : dwell;
            busy  <= 1'b1;
          end
        end
        SCAN: begin
          if (abort) begin
            state    <= IDLE;
            ch       <= 2'd0;
            dcnt     <= '0;
            busy     <= 1'b0;
            {s1, s0} <= 2'b00;
          end else if (dcnt == d_lat) begin
            dcnt <= DWELL_W'(1);
            if (ch != 2'd3) begin
              unique case (ch)
                2'd0:    shadow[0] <= y;
                2'd1:    shadow[1] <= y;
                default: shadow[2] <= y;
              endcase
              ch       <= ch + 2'd1;
              {s1, s0} <= ch + 2'd1;
            end else begin
              snap       <= {y, shadow};
              snap_valid <= 1'b1;
              scan_cnt   <= scan_cnt + CNT_W'(1);
              ch         <= 2'd0;
              {s1, s0}   <= 2'b00;
              // cont is only looked at on this completion edge
              if (!cont) begin
                state <= IDLE;
                busy  <= 1'b0;
                dcnt  <= '0;
              end
            end
          end else begin
            dcnt <= dcnt + DWELL_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mux_scan_ctrl.sv
// Scoreboard bench for mux_scan_ctrl with a behavioural 4:1 mux on y.
// Expected snapshots are queued at stimulus time and popped on snap_valid.
module tb_mux_scan_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start, abort, cont, y;
  logic [7:0] dwell;
  logic       s1, s0, busy, snap_valid;
  logic [3:0] snap;
  logic [7:0] scan_cnt;
  logic [3:0] i_pat;

  mux_scan_ctrl #(.DWELL_W(8), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .cont(cont), .dwell(dwell), .y(y), .s1(s1), .s0(s0),
    .busy(busy), .snap(snap), .snap_valid(snap_valid),
    .scan_cnt(scan_cnt)
  );

  assign y = i_pat[{s1, s0}];

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [3:0] snap;
    logic [7:0] cnt;
    int         tc;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;

  int         m_t0 = 0;
  int         m_d = 1;
  int         m_end = 0;
  logic [7:0] m_cnt = 0;
  int         rst_cnt = 0;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h",
               name, cyc, act, exp);
    end
  endtask

  int         seen_rst = 0;
  logic [3:0] h_snap = 0;
  logic [7:0] h_cnt = 0;

  always @(negedge clk) begin
    if (rst_n) begin
      bit   eb;
      int   es;
      exp_t e;
      if (rst_cnt != seen_rst) begin
        seen_rst = rst_cnt;
        h_snap   = 0;
        h_cnt    = 0;
      end
      eb = (cyc >= m_t0) && (cyc < m_end);
      es = eb ? ((cyc - m_t0) / m_d) % 4 : 0;
      chk("busy", busy, eb);
      chk("sel", {s1, s0}, es);
      if (snap_valid) begin
        if (q.size() == 0) begin
          chk("spurious_valid", snap_valid, 1'b0);
        end else begin
          e = q.pop_front();
          chk("snap", snap, e.snap);
          chk("scan_cnt", scan_cnt, e.cnt);
          chk("valid_time", cyc, e.tc);
          h_snap = e.snap;
          h_cnt  = e.cnt;
        end
      end else begin
        chk("snap_hold", snap, h_snap);
        chk("cnt_hold", scan_cnt, h_cnt);
      end
    end
  end

  task automatic idle(int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk_zero(string tag);
    chk({tag, "_sel"}, {s1, s0}, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_snap"}, snap, 0);
    chk({tag, "_valid"}, snap_valid, 0);
    chk({tag, "_cnt"}, scan_cnt, 0);
  endtask

  // kill: 0 none, 1 abort on edge e0+kill_at, 2 reset after edge e0+kill_at
  task automatic run_scan(int dw, logic [3:0] pat, int nscan,
                          int kill, int kill_at);
    int e0, d, total, stop_at, tc;
    i_pat = pat;
    dwell = 8'(dw);
    cont  = (nscan > 1);
    start = 1'b1;
    @(posedge clk);
    #1;
    start   = 1'b0;
    e0      = cyc;
    d       = (dw == 0) ? 1 : dw;
    total   = 4 * d * nscan;
    stop_at = (kill == 1) ? e0 + kill_at : e0 + total;
    for (int j = 0; j < nscan; j++) begin
      tc = e0 + 4 * d * (j + 1);
      if (kill == 0 || tc < e0 + kill_at) begin
        m_cnt++;
        q.push_back('{snap: pat, cnt: m_cnt, tc: tc});
      end
    end
    m_t0  = e0;
    m_d   = d;
    m_end = stop_at;
    while (cyc < stop_at) begin
      if (kill == 2 && cyc == e0 + kill_at) begin
        #1 rst_n = 1'b0;
        #1 chk_zero("async_rst");
        m_end = cyc;
        m_cnt = 0;
        rst_cnt++;
        start = 1'b0;
        abort = 1'b0;
        cont  = 1'b0;
        #1 rst_n = 1'b1;
        break;
      end
      dwell = 8'($urandom);
      start = 1'($urandom_range(0, 1));
      abort = (kill == 1 && cyc + 1 == e0 + kill_at);
      cont  = (cyc + 1 == e0 + total) ? 1'b0 : (nscan > 1);
      @(posedge clk);
      #1;
    end
    start = 1'b0;
    abort = 1'b0;
    cont  = 1'b0;
    idle(2);
  endtask

  initial begin
    int dw, ns, k, d, tot, ka;
    rst_n = 1'b1;
    start = 1'b0;
    abort = 1'b0;
    cont  = 1'b0;
    dwell = 8'd0;
    i_pat = 4'd0;
    #1 rst_n = 1'b0;
    @(posedge clk);
    #1;
    chk_zero("reset");
    idle(1);
    rst_n = 1'b1;
    idle(2);

    run_scan(1, 4'b1110, 1, 0, 0);
    run_scan(100, 4'b1110, 1, 0, 0);
    run_scan(0, 4'($urandom), 1, 0, 0);
    run_scan(2, 4'b0101, 4, 0, 0);
    run_scan(3, 4'($urandom), 1, 1, 7);
    run_scan(2, 4'($urandom), 1, 1, 8);

    start = 1'b1;
    abort = 1'b1;
    idle(1);
    start = 1'b0;
    abort = 1'b0;
    idle(3);

    run_scan(5, 4'($urandom), 1, 2, 7);
    run_scan(1, 4'($urandom), 256, 0, 0);

    for (int i = 0; i < 25; i++) begin
      dw  = $urandom_range(0, 6);
      ns  = $urandom_range(1, 3);
      k   = $urandom_range(0, 2);
      d   = (dw == 0) ? 1 : dw;
      tot = 4 * d * ns;
      ka  = (k == 1) ? $urandom_range(1, tot) :
            (k == 2) ? $urandom_range(0, tot - 1) : 0;
      run_scan(dw, 4'($urandom), ns, k, ka);
    end

    idle(3);
    chk("queue_empty", q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
